// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: decodes the opcode and emits
// Moore-style enables/selects per state. Optional memory handshake: CTRL_MEM_WAIT_EN.
module mips_multicycle_ctrl (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state;
    state_t state_next;

    logic mem_ok;
    logic pc_write;
    logic branch;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic retire_raw;

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = FETCH;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        retire_raw    = 1'b0;
        case (state)
            FETCH: begin
                alu_src_b    = 2'b01;
                ir_write_raw = mem_ok;
                pc_write     = mem_ok;
                state_next   = mem_ok ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXEC;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        // unknown opcode retires as a NOP
                        state_next = FETCH;
                        retire_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = mem_ok ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                retire_raw    = 1'b1;
            end
            MEMWR: begin
                // write strobe stays up for the whole wait, retire only on completion
                iord          = 1'b1;
                mem_write_raw = 1'b1;
                retire_raw    = mem_ok;
                state_next    = mem_ok ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                retire_raw    = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = 1'b1;
                retire_raw = 1'b1;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                retire_raw    = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                retire_raw = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // reset suppresses every side effect; selects keep following the state
    assign mem_write = mem_write_raw & ~rst_in;
    assign ir_write  = ir_write_raw & ~rst_in;
    assign pc_en     = (pc_write | (branch & zero)) & ~rst_in;
    assign reg_write = reg_write_raw & ~rst_in;
    assign retire    = retire_raw & ~rst_in;
    assign state_o   = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle comparison of all outputs
// against an instruction-step reference model, directed cases then random programs.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

`ifdef CTRL_MEM_WAIT_EN
    localparam bit WAIT = 1'b1;
`else
    localparam bit WAIT = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, retire;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;
    int m_step = 0;

    mips_multicycle_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .pc_en(pc_en),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .retire(retire), .state_o(state_o)
    );

    always #5 clk_in = ~clk_in;

    // instruction latency in cycles, fetch included
    function automatic int lat(input logic [5:0] o);
        case (o)
            LW:            return 5;
            SW, RT, ADDI:  return 4;
            BEQ, JMP:      return 3;
            default:       return 2;
        endcase
    endfunction

    function automatic bit is_mem_step(input logic [5:0] o, input int s);
        return (s == 0) || (s == 3 && (o == LW || o == SW));
    endfunction

    // word layout: {state[18:15], iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
    //               alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retire}
    function automatic logic [18:0] exp_word(input logic [5:0] o, input int s, input logic z);
        logic [3:0] st;
        logic io, mw, iw, pe, sa, rd, mtr, rw, rt;
        logic [1:0] ps, sb, ao;
        st = 4'd0; io = 0; mw = 0; iw = 0; pe = 0; sa = 0; rd = 0; mtr = 0; rw = 0; rt = 0;
        ps = 2'b00; sb = 2'b00; ao = 2'b00;
        if (s == 0) begin
            st = 4'd0; iw = 1; pe = 1; sb = 2'b01;
        end else if (s == 1) begin
            st = 4'd1; sb = 2'b11; rt = (lat(o) == 2);
        end else begin
            case (o)
                LW: begin
                    if (s == 2) begin st = 4'd2; sa = 1; sb = 2'b10; end
                    else if (s == 3) begin st = 4'd3; io = 1; end
                    else begin st = 4'd4; rw = 1; mtr = 1; rt = 1; end
                end
                SW: begin
                    if (s == 2) begin st = 4'd2; sa = 1; sb = 2'b10; end
                    else begin st = 4'd5; io = 1; mw = 1; rt = 1; end
                end
                RT: begin
                    if (s == 2) begin st = 4'd6; sa = 1; ao = 2'b10; end
                    else begin st = 4'd7; rw = 1; rd = 1; rt = 1; end
                end
                ADDI: begin
                    if (s == 2) begin st = 4'd9; sa = 1; sb = 2'b10; end
                    else begin st = 4'd10; rw = 1; rt = 1; end
                end
                BEQ: begin
                    st = 4'd8; sa = 1; ao = 2'b01; ps = 2'b01; pe = z; rt = 1;
                end
                default: begin
                    st = 4'd11; ps = 2'b10; pe = 1; rt = 1;
                end
            endcase
        end
        return {st, io, mw, iw, pe, ps, sa, sb, ao, rd, mtr, rw, rt};
    endfunction

    // drive one cycle at the falling edge, compare, then advance the model
    task automatic do_cycle(input logic [5:0] o, input logic z, input logic mr,
                            input logic rst, input string tag);
        logic [18:0] expv, obs;
        bit hold;
        op = o; zero = z; mem_ready = mr; rst_in = rst;
        #1;
        expv = exp_word(o, m_step, z);
        hold = WAIT && is_mem_step(o, m_step) && !mr;
        if (hold) expv = expv & ~19'h01801;
        if (rst)  expv = expv & ~19'h03803;
        obs = {state_o, iord, mem_write, ir_write, pc_en, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, retire};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s step=%0d op=%b observed=%h expected=%h", tag, m_step, o, obs, expv);
        end
        if (rst) m_step = 0;
        else if (!hold) m_step = (m_step == lat(o) - 1) ? 0 : m_step + 1;
        @(negedge clk_in);
    endtask

    // zmode: 0/1 fixed zero flag, 2 random; rst_pct: per-cycle reset chance
    task automatic run_instr(input logic [5:0] o, input int zmode, input int rst_pct,
                             input string tag);
        int n;
        logic z, mr, r;
        n = 0;
        do begin
            z  = (zmode == 2) ? ($urandom_range(0, 1) == 1) : (zmode == 1);
            mr = WAIT ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 99) < rst_pct);
            do_cycle(o, z, mr, r, tag);
            n++;
        end while (m_step != 0 && n < 40);
        checks++;
        assert (n < 40) else begin
            errors++;
            $error("FAIL %s_timeout cycles=%0d required=<40", tag, n);
        end
    endtask

    initial begin
        logic [5:0] rop;
        rst_in = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        do_cycle(LW, 1'b0, 1'b0, 1'b1, "reset");
        do_cycle(LW, 1'b1, 1'b1, 1'b1, "reset_hold");

        run_instr(LW,   0, 0, "lw");
        run_instr(BEQ,  1, 0, "beq_taken");
        run_instr(BEQ,  0, 0, "beq_not_taken");
        run_instr(RT,   2, 0, "rtype");
        run_instr(ADDI, 2, 0, "addi");
        run_instr(6'b111111, 2, 0, "illegal");
        run_instr(SW,   2, 0, "sw");
        run_instr(JMP,  0, 0, "jump");

        // store with a stalled memory, then a store aborted by reset mid-wait
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_wait_fetch");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_wait_decode");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_wait_memadr");
        for (int i = 0; i < 3; i++) do_cycle(SW, 1'b0, 1'b0, 1'b0, "sw_wait_stall");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_wait_done");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_abort_fetch");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_abort_decode");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_abort_memadr");
        do_cycle(SW, 1'b0, 1'b0, 1'b0, "sw_abort_stall");
        do_cycle(SW, 1'b0, 1'b0, 1'b1, "sw_abort_reset");
        do_cycle(SW, 1'b0, 1'b1, 1'b0, "sw_after_reset");
        run_instr(SW, 0, 0, "sw_resume");

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BEQ;
                4: rop = ADDI;
                5: rop = JMP;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, 2, 4, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
